// File: rtl/ysyx_23060042_pkg.sv
// Shared types and constants for the ysyx_23060042 core memory subsystem.
package ysyx_23060042_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_arb_state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060042_mem_arb.sv
// Round-robin IFU/LSU arbiter onto a single memory port, one access in flight,
// with a sticky watchdog flag for a memory that never answers.
module ysyx_23060042_mem_arb
  import ysyx_23060042_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_addr,
  output logic        if_rvalid,
  input  logic        ls_valid,
  output logic        ls_ready,
  input  logic [31:0] ls_addr,
  input  logic        ls_wen,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wmask,
  output logic        ls_rvalid,
  output logic [31:0] rdata,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_wen,
  output logic [3:0]  m_wmask,
  input  logic        m_resp_valid,
  input  logic [31:0] m_rdata,
  output logic        timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mem_arb_state_t state, state_nxt;
  logic           last;
  logic           owner;
  logic           grant;
  logic           grant_vld;
  logic [CW-1:0]  wd_cnt;

  assign m_req_valid = (state == REQ);
  assign rdata       = m_rdata;

  always_comb begin
    state_nxt = state;
    grant     = OWN_IFU;
    grant_vld = 1'b0;
    if_ready  = 1'b0;
    ls_ready  = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester that did not win last time goes next.
        if (if_valid && ls_valid) grant = ~last;
        else if (ls_valid)        grant = OWN_LSU;
        else                      grant = OWN_IFU;
        grant_vld = if_valid | ls_valid;
        if_ready  = grant_vld && (grant == OWN_IFU);
        ls_ready  = grant_vld && (grant == OWN_LSU);
        if (grant_vld) state_nxt = REQ;
      end
      REQ: begin
        if (m_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (m_resp_valid) begin
          if (owner == OWN_IFU) if_rvalid = 1'b1;
          else                  ls_rvalid = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= OWN_LSU;
      owner   <= OWN_IFU;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wen   <= 1'b0;
      m_wmask <= '0;
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_vld) begin
        owner <= grant;
        last  <= grant;
        if (grant == OWN_IFU) begin
          m_addr  <= if_addr;
          m_wdata <= '0;
          m_wen   <= 1'b0;
          m_wmask <= '0;
        end else begin
          m_addr  <= ls_addr;
          m_wdata <= ls_wdata;
          m_wen   <= ls_wen;
          m_wmask <= ls_wmask;
        end
      end
      if (state == REQ && m_req_ready) begin
        wd_cnt <= '0;
      end else if (state == WAIT && !m_resp_valid) begin
        if (wd_cnt != CW'(TIMEOUT)) wd_cnt <= wd_cnt + CW'(1);
        // Registered one cycle early so the flag is visible in the TIMEOUT-th WAIT cycle.
        if (wd_cnt == CW'(TIMEOUT - 2)) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060042_mem_arb.sv
// Directed plus randomized bench for ysyx_23060042_mem_arb against a transaction-level model.
module tb_ysyx_23060042_mem_arb;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0, ls_valid = 1'b0, ls_wen = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0, m_rdata = '0;
  logic [3:0]  ls_wmask = '0;
  logic        m_req_ready = 1'b0, m_resp_valid = 1'b0;
  logic        if_ready, ls_ready, if_rvalid, ls_rvalid, m_req_valid, m_wen, timeout;
  logic [31:0] rdata, m_addr, m_wdata;
  logic [3:0]  m_wmask;

  always #5 clk = ~clk;

  ysyx_23060042_mem_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr), .if_rvalid(if_rvalid),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_addr(ls_addr), .ls_wen(ls_wen),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_rvalid(ls_rvalid), .rdata(rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wen(m_wen), .m_wmask(m_wmask),
    .m_resp_valid(m_resp_valid), .m_rdata(m_rdata), .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: busy flag for "a transfer is in flight", a flag for
  // "memory has taken it", the recorded access, and an elapsed-wait counter.
  bit          busy, issued, owner_lsu, last_lsu, tflag;
  int          waited;
  logic [31:0] rec_addr, rec_wdata;
  logic        rec_wen;
  logic [3:0]  rec_wmask;

  task automatic model_reset();
    busy = 0; issued = 0; owner_lsu = 0; last_lsu = 1; tflag = 0; waited = 0;
    rec_addr = '0; rec_wdata = '0; rec_wen = 1'b0; rec_wmask = '0;
  endtask

  function automatic bit winner_lsu();
    if (if_valid && ls_valid) return !last_lsu;
    return ls_valid;
  endfunction

  task automatic model_step();
    if (!busy) begin
      if (if_valid || ls_valid) begin
        owner_lsu = winner_lsu();
        last_lsu  = owner_lsu;
        busy      = 1;
        issued    = 0;
        if (owner_lsu) begin
          rec_addr = ls_addr; rec_wdata = ls_wdata; rec_wen = ls_wen; rec_wmask = ls_wmask;
        end else begin
          rec_addr = if_addr; rec_wdata = '0; rec_wen = 1'b0; rec_wmask = '0;
        end
      end
    end else if (!issued) begin
      if (m_req_ready) begin
        issued = 1;
        waited = 0;
      end
    end else if (m_resp_valid) begin
      busy = 0;
    end else begin
      waited++;
      if (waited == TO - 1) tflag = 1;
    end
  endtask

  task automatic check_outs();
    bit idle, lsw, resp;
    idle = !busy;
    lsw  = winner_lsu();
    resp = busy && issued && m_resp_valid;
    chk("if_ready", if_ready, idle && if_valid && !lsw);
    chk("ls_ready", ls_ready, idle && ls_valid && lsw);
    chk("m_req_valid", m_req_valid, busy && !issued);
    chk("m_addr", m_addr, rec_addr);
    chk("m_wdata", m_wdata, rec_wdata);
    chk("m_wen_wmask", {m_wen, m_wmask}, {rec_wen, rec_wmask});
    chk("if_rvalid", if_rvalid, resp && !owner_lsu);
    chk("ls_rvalid", ls_rvalid, resp && owner_lsu);
    chk("rdata", rdata, m_rdata);
    chk("timeout", timeout, tflag);
  endtask

  task automatic cyc(input bit iv, input logic [31:0] ia, input bit lv, input logic [31:0] la,
                     input bit we, input logic [31:0] wd, input logic [3:0] wm,
                     input bit rr, input bit rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    model_step();
    if_valid = iv; if_addr = ia; ls_valid = lv; ls_addr = la; ls_wen = we;
    ls_wdata = wd; ls_wmask = wm; m_req_ready = rr; m_resp_valid = rv; m_rdata = rd;
    @(negedge clk);
    check_outs();
  endtask

  task automatic mem(input bit rr, input bit rv, input logic [31:0] rd);
    cyc(0, '0, 0, '0, 0, '0, '0, rr, rv, rd);
  endtask

  task automatic do_reset();
    if_valid = 0; ls_valid = 0; ls_wen = 0; m_req_ready = 0; m_resp_valid = 0;
    rst = 1'b1;
    #1;
    model_reset();
    check_outs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // IFU read alone
    cyc(1, 32'h8000_0000, 0, '0, 0, '0, '0, 0, 0, '0);
    mem(1, 0, '0);
    mem(0, 1, 32'h0000_0413);
    chk("ifu_read_rvalid", if_rvalid, 1'b1);
    mem(0, 0, '0);

    // LSU store
    cyc(0, '0, 1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'b0011, 0, 0, '0);
    mem(1, 0, '0);
    chk("store_wmask", {28'd0, m_wmask}, 32'h3);
    mem(0, 1, '0);
    mem(0, 0, '0);

    // Tie: both valid, fastest memory; grants must alternate
    for (int i = 0; i < 12; i++)
      cyc(1, 32'h100 + i, 1, 32'h200 + i, i[0], 32'h55 + i, 4'hF, 1, 1, 32'h1000 + i);
    mem(0, 0, '0);

    // Slow memory, watchdog fires during the wait, response still delivered
    cyc(0, '0, 1, 32'h8000_2000, 0, '0, 4'h0, 0, 0, '0);
    for (int i = 0; i < 5; i++) cyc(1, 32'h44, 1, 32'h88, 0, '0, '0, 0, 0, '0);
    cyc(1, 32'h44, 0, '0, 0, '0, '0, 1, 0, '0);
    for (int i = 0; i < 7; i++) cyc(1, 32'h44, 0, '0, 0, '0, '0, 0, 0, '0);
    cyc(1, 32'h44, 0, '0, 0, '0, '0, 0, 1, 32'hCAFE_F00D);
    chk("slow_ls_rvalid", ls_rvalid, 1'b1);
    chk("slow_timeout", timeout, 1'b1);
    mem(1, 0, '0);
    mem(0, 1, 32'h77);
    mem(0, 0, '0);

    // Reset mid-WAIT, then a late response
    do_reset();
    cyc(1, 32'h8000_0040, 0, '0, 0, '0, '0, 0, 0, '0);
    mem(1, 0, '0);
    mem(0, 0, '0);
    do_reset();
    mem(0, 1, 32'h1234_5678);
    chk("late_resp_no_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);

    // Randomized traffic with varying memory latency and occasional resets
    for (int i = 0; i < 4000; i++) begin
      int rr_pct, rv_pct;
      if (($urandom % 250) == 0) do_reset();
      rr_pct = ((i / 300) % 2 == 0) ? 60 : 20;
      rv_pct = ((i / 500) % 2 == 0) ? 50 : 12;
      cyc(($urandom % 3) != 0, $urandom, ($urandom % 3) != 0, $urandom, $urandom % 2,
          $urandom, 4'($urandom), ($urandom % 100) < rr_pct, ($urandom % 100) < rv_pct, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060042_mem_arb.md
# ysyx_23060042_mem_arb

Two-requester memory arbiter for the multi-cycle core. It shares the single memory port between the IFU (instruction fetch, read-only) and the LSU (load/store). It serialises accesses with at most one transaction outstanding and routes each response back to its owner. A watchdog counter flags a memory port that never responds.

## Interface
- `TIMEOUT`, default 1024: cycles spent in WAIT before `timeout` sets; must be ≥2.
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_valid`  in  1  IFU read request
- `if_ready`  out  1  IFU request accepted this cycle
- `if_addr`  in  32  IFU read address
- `if_rvalid`  out  1  IFU response strobe, one cycle
- `ls_valid`  in  1  LSU request
- `ls_ready`  out  1  LSU request accepted this cycle
- `ls_addr`  in  32  LSU address
- `ls_wen`  in  1  1 = store, 0 = load
- `ls_wdata`  in  32  store data
- `ls_wmask`  in  4  byte strobes for a store
- `ls_rvalid`  out  1  LSU response strobe, one cycle (load data or store ack)
- `rdata`  out  32  response data, shared by both requesters, = `m_rdata`
- `m_req_valid`  out  1  memory request valid
- `m_req_ready`  in  1  memory accepts request
- `m_addr`, `m_wdata`  out  32  latched address / write data
- `m_wen`  out  1; `m_wmask` out 4  latched write enable / strobes (0 for IFU)
- `m_resp_valid`  in  1  memory response (read data or write ack)
- `m_rdata`  in  32  memory read data
- `timeout`  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE:**
  - Arbitrate among valid requesters and raise `*_ready` combinationally for the winner only.
  - On `valid & ready`, latch addr/wen/wdata/wmask and the owner, set `last` = owner, go to REQ.
  - An IFU grant latches `wen=0` and `wmask=0`.
- **Arbitration:** round-robin on `last`.
  - If both requesters are valid, grant the one not equal to `last`.
  - If only one is valid, grant it.
- **REQ:** `m_req_valid=1` with the latched fields. On `m_req_ready`, go to WAIT.
- **WAIT:**
  - `m_resp_valid` asserts the owner's `*_rvalid` combinationally in the same cycle, then the FSM goes to IDLE.
  - Requesters cannot back-pressure responses.
- **Watchdog:**
  - The counter clears on entering WAIT and increments each WAIT cycle without a response.
  - When the count reaches `TIMEOUT`, `timeout` sets and stays set until `rst`.
  - The FSM keeps waiting.
- Latched fields hold stable from acceptance until return to IDLE.
- Requester inputs are ignored outside IDLE.
- `m_resp_valid` outside WAIT is ignored: no `*_rvalid`, no state change.

## Timing
- **Reset values:**
  - FSM = IDLE, `last` = LSU, so IFU wins the first tie.
  - All `m_*` outputs = 0, `timeout` = 0, watchdog counter = 0.
  - `rdata` follows `m_rdata`.
- **Minimum transaction:** accept at cycle N, `m_req_valid` at N+1. With `m_req_ready`=1 at N+1 and `m_resp_valid`=1 at N+2: `*_rvalid` at N+2, next accept possible at N+3. That is 3 cycles per access.
- **Back-to-back:** a requester that holds `valid` through its response is re-arbitrated at IDLE. It loses to a waiting peer.
- **`rst` mid-transaction:** immediate return to IDLE and any outstanding access is abandoned. A late `m_resp_valid` after reset produces no strobe.
- **Same-cycle `m_req_ready` and `m_resp_valid` in REQ:** the response is not taken. The memory must respond at least one cycle after acceptance.
- The watchdog counter saturates at `TIMEOUT`. Width is $clog2(`TIMEOUT`+1).

## Structure
- Shared package `ysyx_23060042_pkg`:
  - `mem_arb_state_t` enum {IDLE, REQ, WAIT}.
  - Owner encoding constants `OWN_IFU=1'b0`, `OWN_LSU=1'b1`.
- No sub-module is needed. The request latch and watchdog are inline in one `always_ff` with async reset. Grant and response routing are in one `always_comb`.

## Test plan
- **IFU read alone:** `if_valid`, `if_addr=0x80000000`, memory ready immediately, `m_rdata=0x00000413` one cycle later → `if_ready` at N, `m_addr=0x80000000` with `m_wen=0` at N+1, `if_rvalid=1` and `rdata=0x00000413` at N+2, `ls_rvalid` stays 0.
- **LSU store:** `ls_addr=0x80001000`, `ls_wdata=0xDEADBEEF`, `ls_wmask=4'b0011` → `m_wen=1`, `m_wmask=0011`, `m_wdata=0xDEADBEEF`, then `ls_rvalid` on ack.
- **Tie after reset:** both valid continuously → grants IFU, LSU, IFU, LSU alternating. Each grant appears only in IDLE.
- **Slow memory:** `m_req_ready` low 5 cycles, `m_resp_valid` 7 cycles later → fields stable throughout, single `*_rvalid` pulse, no new `*_ready` before it.
- **Watchdog:** `TIMEOUT=4`, no response → `timeout`=1 on the 4th WAIT cycle. A later response still delivers `*_rvalid`, and `timeout` stays 1.
- **Reset mid-WAIT:** assert `rst` during WAIT, then `m_resp_valid` → no `*_rvalid`, FSM IDLE, `m_req_valid`=0, `timeout`=0.
